// File: rtl/hm2_gpio_mux_pkg.sv
// hm2_gpio_mux_pkg: shared map/FSM encodings and the pin-map arithmetic
// used by the HostMot2 GPIO header mux.
package hm2_gpio_mux_pkg;

    // Bit 0 selects header swap, bit 1 selects pin reversal.
    typedef enum logic [1:0] {
        MAP_STRAIGHT     = 2'd0,
        MAP_SWAP         = 2'd1,
        MAP_REVERSE      = 2'd2,
        MAP_SWAP_REVERSE = 2'd3
    } map_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_APPLY,
        ST_SETTLE,
        ST_DONE
    } state_e;

    // Flat pad index (header * gpio_w + pin) that I/O bit k lands on.
    function automatic int phys_index(
        input int         k,
        input logic [1:0] m,
        input int         mux_w,
        input int         num_gpio,
        input int         gpio_w
    );
        int h;
        int p;
        h = k / mux_w;
        p = k % mux_w;
        if (m[0]) h = num_gpio - 1 - h;
        if (m[1]) p = mux_w - 1 - p;
        return h * gpio_w + p;
    endfunction

endpackage

// File: rtl/hm2_sync_bus.sv
// hm2_sync_bus: Stages-deep, Width-wide synchroniser, async active-low reset.
// Ports: clk, reset_n, d (async in), q (synchronised out).
module hm2_sync_bus #(
    parameter int Width  = 1,
    parameter int Stages = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] stg [Stages];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < Stages; i++) stg[i] <= '0;
        end else begin
            stg[0] <= d;
            for (int i = 1; i < Stages; i++) stg[i] <= stg[i-1];
        end
    end

    assign q = stg[Stages-1];

endmodule

// File: rtl/hm2_gpio_mux.sv
// hm2_gpio_mux: run-time selectable pin map between the hostmot2 I/O bus
// and the expansion headers, with a drain/apply/settle remap handshake.
// Ports: clk, reset_n; io_out/io_oe/io_in (core side); map_sel, map_req,
// map_busy, map_ack, active_map (remap control); gpio_out/gpio_oe/gpio_in
// (pad side). HM2_GPIO_MUX_LOOPBACK_EN adds input loopback.
module hm2_gpio_mux
    import hm2_gpio_mux_pkg::*;
#(
    parameter int IOWidth     = 72,
    parameter int NumGPIO     = 2,
    parameter int GPIOWidth   = 36,
    parameter int MuxWidth    = IOWidth / NumGPIO,
    parameter int SyncStages  = 2,
    parameter int GuardCycles = 16,
    parameter int DefaultMap  = 0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [IOWidth-1:0]           io_out,
    input  logic [IOWidth-1:0]           io_oe,
    output logic [IOWidth-1:0]           io_in,
    input  logic [1:0]                   map_sel,
    input  logic                         map_req,
    output logic                         map_busy,
    output logic                         map_ack,
    output logic [1:0]                   active_map,
    output logic [NumGPIO*GPIOWidth-1:0] gpio_out,
    output logic [NumGPIO*GPIOWidth-1:0] gpio_oe,
`ifdef HM2_GPIO_MUX_LOOPBACK_EN
    input  logic                         loopback,
`endif
    input  logic [NumGPIO*GPIOWidth-1:0] gpio_in
);

    localparam int PW = NumGPIO * GPIOWidth;
    localparam int IW = $clog2(PW);
    localparam int CW = $clog2(GuardCycles + SyncStages + 2);

    state_e        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    map_e          pending, pend_d;
    map_e          map_q, map_d;

    logic [PW-1:0]      pad_sync;
    logic [PW-1:0]      out_d, oe_d;
    logic [IOWidth-1:0] in_d;
    logic [IW-1:0]      idx;
    logic               lb_on;

    hm2_sync_bus #(.Width(PW), .Stages(SyncStages)) u_pad_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (gpio_in),
        .q       (pad_sync)
    );

`ifdef HM2_GPIO_MUX_LOOPBACK_EN
    logic [IOWidth-1:0] lb_sync;

    hm2_sync_bus #(.Width(IOWidth), .Stages(SyncStages)) u_lb_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (io_out),
        .q       (lb_sync)
    );

    assign lb_on = loopback;
`else
    assign lb_on = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pending <= map_e'(2'(DefaultMap));
            map_q   <= map_e'(2'(DefaultMap));
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            pending <= pend_d;
            map_q   <= map_d;
        end
    end

    // The new map is loaded on the DRAIN->APPLY edge so it is already
    // visible while APPLY is the current state.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        pend_d  = pending;
        map_d   = map_q;
        unique case (state)
            ST_IDLE: begin
                if (map_req) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CW'(GuardCycles - 1);
                    pend_d  = map_e'(map_sel);
                end
            end
            ST_DRAIN: begin
                if (cnt == '0) begin
                    state_d = ST_APPLY;
                    map_d   = pending;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            ST_APPLY: begin
                state_d = ST_SETTLE;
                cnt_d   = CW'(SyncStages);
            end
            ST_SETTLE: begin
                if (cnt == '0) state_d = ST_DONE;
                else           cnt_d   = cnt - 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Same index drives the pad and reads it back, so the input map is
    // the inverse of the output map by construction.
    always_comb begin
        out_d = '0;
        oe_d  = '0;
        in_d  = '0;
        idx   = '0;
        for (int k = 0; k < IOWidth; k++) begin
            idx = IW'(phys_index(k, map_q, MuxWidth, NumGPIO, GPIOWidth));
            out_d[idx] = io_out[k];
            oe_d[idx]  = io_oe[k];
            in_d[k]    = pad_sync[idx];
        end
`ifdef HM2_GPIO_MUX_LOOPBACK_EN
        if (loopback) in_d = lb_sync;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gpio_out <= '0;
            gpio_oe  <= '0;
            io_in    <= '0;
        end else begin
            gpio_out <= out_d;
            gpio_oe  <= (state == ST_DRAIN || lb_on) ? '0 : oe_d;
            if (state != ST_SETTLE) io_in <= in_d;
        end
    end

    assign map_busy   = (state != ST_IDLE);
    assign map_ack    = (state == ST_DONE);
    assign active_map = map_q;

endmodule

// File: tb/tb_hm2_gpio_mux.sv
// tb_hm2_gpio_mux: randomized scoreboard bench for hm2_gpio_mux with a
// timeline-based reference model of the remap handshake.
module tb_hm2_gpio_mux;

    localparam int IOW  = 72;
    localparam int NG   = 2;
    localparam int GWID = 36;
    localparam int MW   = IOW / NG;
    localparam int GW   = NG * GWID;
    localparam int S    = 2;
    localparam int G    = 16;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [IOW-1:0] io_out, io_oe, io_in;
    logic [1:0]     map_sel;
    logic           map_req, map_busy, map_ack;
    logic [1:0]     active_map;
    logic [GW-1:0]  gpio_out, gpio_oe, gpio_in;
`ifdef HM2_GPIO_MUX_LOOPBACK_EN
    logic           loopback;
`endif

    hm2_gpio_mux dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .io_out     (io_out),
        .io_oe      (io_oe),
        .io_in      (io_in),
        .map_sel    (map_sel),
        .map_req    (map_req),
        .map_busy   (map_busy),
        .map_ack    (map_ack),
        .active_map (active_map),
        .gpio_out   (gpio_out),
        .gpio_oe    (gpio_oe),
`ifdef HM2_GPIO_MUX_LOOPBACK_EN
        .loopback   (loopback),
`endif
        .gpio_in    (gpio_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int            stamp;
        logic [GW-1:0] out;
        logic [GW-1:0] oe;
        logic          busy;
        logic          ack;
        logic [1:0]    amap;
    } out_rec_t;

    typedef struct {
        int             stamp;
        logic [IOW-1:0] v;
    } in_rec_t;

    out_rec_t q_out[$];
    in_rec_t  q_in[$];

    // Reference model: a remap accepted at edge acc switches the map from
    // prev_m to pend_m at edge acc+G; all other timing is offsets from acc.
    int             acc = -1000;
    logic [1:0]     prev_m = 2'd0;
    logic [1:0]     pend_m = 2'd0;
    logic [IOW-1:0] last_in = '0;

    function automatic logic [1:0] map_at(int n);
        return (n >= acc + G) ? pend_m : prev_m;
    endfunction

    function automatic int pad_of(int k, logic [1:0] m);
        int h;
        int p;
        h = k / MW;
        p = k % MW;
        if (m == 2'd1 || m == 2'd3) h = NG - 1 - h;
        if (m == 2'd2 || m == 2'd3) p = MW - 1 - p;
        return h * GWID + p;
    endfunction

    function automatic logic [IOW-1:0] rnd72();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[IOW-1:0];
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h",
                     name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and push what the DUT must show for it.
    task automatic step(input logic [IOW-1:0] o, input logic [IOW-1:0] oe,
                        input logic [GW-1:0] gi, input logic req,
                        input logic [1:0] sel);
        int       n;
        int       t;
        out_rec_t r;
        in_rec_t  ri;
        logic [1:0] m;
        n = cyc + 1;
        io_out  = o;
        io_oe   = oe;
        gpio_in = gi;
        map_req = req;
        map_sel = sel;
        if (req && n >= acc + G + S + 4) begin
            prev_m = map_at(n);
            pend_m = sel;
            acc    = n;
        end
        r.stamp = n;
        r.out   = '0;
        r.oe    = '0;
        m = map_at(n - 1);
        for (int k = 0; k < IOW; k++) begin
            r.out[pad_of(k, m)] = o[k];
            r.oe[pad_of(k, m)]  = oe[k];
        end
        if (n >= acc + 1 && n <= acc + G) r.oe = '0;
        r.busy = (n >= acc && n <= acc + G + S + 2);
        r.ack  = (n == acc + G + S + 2);
        r.amap = map_at(n);
        q_out.push_back(r);
        t = n + S;
        ri.stamp = t;
        if (t >= acc + G + 2 && t <= acc + G + S + 2) begin
            ri.v = last_in;
        end else begin
            m = map_at(t - 1);
            for (int k = 0; k < IOW; k++) ri.v[k] = gi[pad_of(k, m)];
        end
        last_in = ri.v;
        q_in.push_back(ri);
        @(posedge clk);
        #1;
    endtask

    task automatic step_rand(input logic req, input logic [1:0] sel);
        step(rnd72(), rnd72(), rnd72(), req, sel);
    endtask

    always @(negedge clk) begin
        if (q_out.size() > 0 && q_out[0].stamp == cyc) begin
            out_rec_t r;
            r = q_out.pop_front();
            chk("gpio_out", 128'(gpio_out), 128'(r.out));
            chk("gpio_oe", 128'(gpio_oe), 128'(r.oe));
            chk("map_busy", 128'(map_busy), 128'(r.busy));
            chk("map_ack", 128'(map_ack), 128'(r.ack));
            chk("active_map", 128'(active_map), 128'(r.amap));
        end
        if (q_in.size() > 0 && q_in[0].stamp == cyc) begin
            in_rec_t ri;
            ri = q_in.pop_front();
            chk("io_in", 128'(io_in), 128'(ri.v));
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 30 && (cyc + 1) < acc + G + S + 4; i++)
            step_rand(1'b0, 2'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        io_out  = '0;
        io_oe   = '0;
        gpio_in = '0;
        map_req = 1'b0;
        map_sel = 2'd0;
`ifdef HM2_GPIO_MUX_LOOPBACK_EN
        loopback = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gpio_out", 128'(gpio_out), 128'd0);
        chk("rst_gpio_oe", 128'(gpio_oe), 128'd0);
        chk("rst_io_in", 128'(io_in), 128'd0);
        chk("rst_busy", 128'(map_busy), 128'd0);
        chk("rst_ack", 128'(map_ack), 128'd0);
        chk("rst_map", 128'(active_map), 128'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 600; i++)
            step_rand($urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)));

        // Remap to swap, with a second request dropped mid-drain.
        wait_idle();
        step_rand(1'b1, 2'd1);
        for (int i = 1; i < 30; i++)
            step_rand(i == 5, 2'd2);
        step(72'h1, 72'h1, rnd72(), 1'b0, 2'd0);
        chk("swap_pin36_out", 128'(gpio_out[36]), 128'd1);
        chk("swap_pin36_oe", 128'(gpio_oe[36]), 128'd1);
        chk("swap_map", 128'(active_map), 128'd1);

        // Reset partway through a drain.
        wait_idle();
        step_rand(1'b1, 2'd2);
        for (int i = 0; i < 7; i++) step_rand(1'b0, 2'd0);
        q_out.delete();
        q_in.delete();
        map_req = 1'b0;
        reset_n = 1'b0;
        #2;
        chk("mid_rst_out", 128'(gpio_out), 128'd0);
        chk("mid_rst_oe", 128'(gpio_oe), 128'd0);
        chk("mid_rst_io_in", 128'(io_in), 128'd0);
        chk("mid_rst_busy", 128'(map_busy), 128'd0);
        chk("mid_rst_ack", 128'(map_ack), 128'd0);
        chk("mid_rst_map", 128'(active_map), 128'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        acc     = -1000;
        prev_m  = 2'd0;
        pend_m  = 2'd0;
        last_in = '0;
        for (int i = 0; i < 30; i++) step_rand(1'b0, 2'd0);

        repeat (4) @(posedge clk);
        #1;
        chk("queues_drained", 128'(q_out.size() + q_in.size()), 128'd0);

`ifdef HM2_GPIO_MUX_LOOPBACK_EN
        loopback = 1'b1;
        io_out   = 72'hA5;
        io_oe    = '1;
        repeat (3) @(posedge clk);
        #1;
        chk("lb_io_in", 128'(io_in), 128'h A5);
        chk("lb_gpio_oe", 128'(gpio_oe), 128'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
